// File: rtl/mem_pkg.sv
// Shared types and default widths for the pipeline memory stage.
// The struct layouts are fixed to the default widths below.
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  jal_inst;
        logic                  reg_write_en;
        logic [DEF_SEL_W-1:0]  reg_write_sel;
        logic [DEF_DATA_W-1:0] alu_res;
        logic [DEF_DATA_W-1:0] write_data;
        logic [DEF_DATA_W-1:0] next_pc;
    } ex_mem_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  jal_inst;
        logic                  reg_write_en;
        logic [DEF_SEL_W-1:0]  reg_write_sel;
        logic [DEF_DATA_W-1:0] alu_res;
        logic [DEF_DATA_W-1:0] mem_read_out;
        logic [DEF_DATA_W-1:0] next_pc;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response channel between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads either a full bundle or a zeroed bubble
// every cycle, so each bundle is presented to writeback for exactly one cycle.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_bundle,
    input  mem_wb_t               bundle_in,
    output logic                  wb_valid,
    output logic                  wb_MemToReg,
    output logic                  wb_JALInst,
    output logic                  wb_RegWriteEn,
    output logic [DEF_SEL_W-1:0]  wb_RegWriteSel,
    output logic [DEF_DATA_W-1:0] wb_ALURes,
    output logic [DEF_DATA_W-1:0] wb_memReadOut,
    output logic [DEF_DATA_W-1:0] wb_next_PC
);

    logic    valid_d, valid_q;
    mem_wb_t wb_d, wb_q;

    always_comb begin
        valid_d = load_bundle;
        wb_d    = '0;
        if (load_bundle) begin
            wb_d = bundle_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
        end
    end

    assign wb_valid       = valid_q;
    assign wb_MemToReg    = wb_q.mem_to_reg;
    assign wb_JALInst     = wb_q.jal_inst;
    // Writeback must never see a write enable on a bubble.
    assign wb_RegWriteEn  = wb_q.reg_write_en & valid_q;
    assign wb_RegWriteSel = wb_q.reg_write_sel;
    assign wb_ALURes      = wb_q.alu_res;
    assign wb_memReadOut  = wb_q.mem_read_out;
    assign wb_next_PC     = wb_q.next_pc;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes non-memory bundles straight to MEM/WB and runs a
// REQ/RESP handshake with data memory for loads and stores, stalling EX meanwhile.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemToReg,
    input  logic              ex_JALInst,
    input  logic              ex_RegWriteEn,
    input  logic [SEL_W-1:0]  ex_RegWriteSel,
    input  logic [DATA_W-1:0] ex_ALURes,
    input  logic [DATA_W-1:0] ex_WriteData,
    input  logic [DATA_W-1:0] ex_next_PC,

    mem_stage_if.master       dmem,

    output logic              wb_valid,
    output logic              wb_MemToReg,
    output logic              wb_JALInst,
    output logic              wb_RegWriteEn,
    output logic [SEL_W-1:0]  wb_RegWriteSel,
    output logic [DATA_W-1:0] wb_ALURes,
    output logic [DATA_W-1:0] wb_memReadOut,
    output logic [DATA_W-1:0] wb_next_PC
);

    mem_state_e state_d, state_q;
    ex_mem_t    hold_d, hold_q;
    ex_mem_t    ex_in;
    mem_wb_t    wb_in;
    logic       wb_load;

    assign ex_in.mem_read      = ex_MemRead;
    assign ex_in.mem_write     = ex_MemWrite;
    assign ex_in.mem_to_reg    = ex_MemToReg;
    assign ex_in.jal_inst      = ex_JALInst;
    assign ex_in.reg_write_en  = ex_RegWriteEn;
    assign ex_in.reg_write_sel = ex_RegWriteSel;
    assign ex_in.alu_res       = ex_ALURes;
    assign ex_in.write_data    = ex_WriteData;
    assign ex_in.next_pc       = ex_next_PC;

    // Request fields come only from the hold register, so they stay stable
    // for as long as the memory holds off ready.
    assign dmem.req_valid = (state_q == REQ);
    assign dmem.req_we    = hold_q.mem_write;
    assign dmem.req_addr  = hold_q.alu_res[ADDR_W-1:0];
    assign dmem.req_wdata = hold_q.write_data;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ex_ready = 1'b0;
        wb_load  = 1'b0;

        wb_in.mem_to_reg    = hold_q.mem_to_reg;
        wb_in.jal_inst      = hold_q.jal_inst;
        wb_in.reg_write_en  = hold_q.reg_write_en;
        wb_in.reg_write_sel = hold_q.reg_write_sel;
        wb_in.alu_res       = hold_q.alu_res;
        wb_in.mem_read_out  = '0;
        wb_in.next_pc       = hold_q.next_pc;

        case (state_q)
            IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) begin
                    if (ex_in.mem_read || ex_in.mem_write) begin
                        hold_d  = ex_in;
                        state_d = REQ;
                    end else begin
                        wb_load             = 1'b1;
                        wb_in.mem_to_reg    = ex_in.mem_to_reg;
                        wb_in.jal_inst      = ex_in.jal_inst;
                        wb_in.reg_write_en  = ex_in.reg_write_en;
                        wb_in.reg_write_sel = ex_in.reg_write_sel;
                        wb_in.alu_res       = ex_in.alu_res;
                        wb_in.next_pc       = ex_in.next_pc;
                    end
                end
            end
            REQ: begin
                if (dmem.req_ready) begin
                    // A bundle with both controls set is a store with zero read data.
                    if (hold_q.mem_read && !hold_q.mem_write) begin
                        state_d = RESP;
                    end else begin
                        wb_load = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (dmem.rsp_valid) begin
                    wb_load            = 1'b1;
                    wb_in.mem_read_out = dmem.rsp_rdata;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_bundle    (wb_load),
        .bundle_in      (wb_in),
        .wb_valid       (wb_valid),
        .wb_MemToReg    (wb_MemToReg),
        .wb_JALInst     (wb_JALInst),
        .wb_RegWriteEn  (wb_RegWriteEn),
        .wb_RegWriteSel (wb_RegWriteSel),
        .wb_ALURes      (wb_ALURes),
        .wb_memReadOut  (wb_memReadOut),
        .wb_next_PC     (wb_next_PC)
    );

endmodule
